// File: rtl/hiscore_upload.sv
// HPS upload server: halts the game CPU and answers ioctl byte reads from the hiscore/work RAM.
// Optional HISCORE_UPLOAD_CHECKSUM_EN serves a negated byte-sum checksum at address SIZE.
module hiscore_upload #(
  parameter int          AW        = 10,
  parameter int          SIZE      = 64,
  parameter int          RD_LAT    = 1,
  parameter int          PAUSE_TMO = 4095,
  parameter logic [7:0]  FILL      = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          tmo_flag
);

  localparam int                TMO_W   = (PAUSE_TMO < 2) ? 1 : $clog2(PAUSE_TMO + 1);
  localparam logic [TMO_W-1:0]  TMO_END = TMO_W'(PAUSE_TMO);
  localparam logic [24:0]       SIZE_A  = 25'(SIZE);
  localparam logic [1:0]        LAT_END = 2'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_READ,
    S_DATA,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic              upload_prev_q, upload_prev_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              pending_q, pending_d;
  logic [24:0]       pend_addr_q, pend_addr_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic              ram_rd_q, ram_rd_d;
  logic              pause_req_q, pause_req_d;
  logic              tmo_flag_q, tmo_flag_d;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              from_ram_q, from_ram_d;
`endif

  logic              req_valid;
  logic [24:0]       req_addr;
  logic              req_ram;
  logic              busy;

  // A request latched during PAUSE takes precedence over a fresh strobe.
  assign req_valid = pending_q | ioctl_rd;
  assign req_addr  = pending_q ? pend_addr_q : ioctl_addr;
  assign req_ram   = (req_addr < SIZE_A);
  assign busy      = (state_q == S_PAUSE) || (state_q == S_READY) ||
                     (state_q == S_READ)  || (state_q == S_DATA);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      upload_prev_q <= 1'b0;
      tmo_cnt_q     <= '0;
      lat_cnt_q     <= '0;
      pending_q     <= 1'b0;
      pend_addr_q   <= '0;
      din_q         <= '0;
      wait_q        <= 1'b0;
      ram_addr_q    <= '0;
      ram_rd_q      <= 1'b0;
      pause_req_q   <= 1'b0;
      tmo_flag_q    <= 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_q         <= '0;
      from_ram_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      upload_prev_q <= upload_prev_d;
      tmo_cnt_q     <= tmo_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      pending_q     <= pending_d;
      pend_addr_q   <= pend_addr_d;
      din_q         <= din_d;
      wait_q        <= wait_d;
      ram_addr_q    <= ram_addr_d;
      ram_rd_q      <= ram_rd_d;
      pause_req_q   <= pause_req_d;
      tmo_flag_q    <= tmo_flag_d;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_q         <= sum_d;
      from_ram_q    <= from_ram_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    upload_prev_d = ioctl_upload;
    tmo_cnt_d     = tmo_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    pending_d     = pending_q;
    pend_addr_d   = pend_addr_q;
    din_d         = din_q;
    wait_d        = wait_q;
    ram_addr_d    = ram_addr_q;
    ram_rd_d      = 1'b0;
    pause_req_d   = pause_req_q;
    tmo_flag_d    = tmo_flag_q;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    sum_d         = sum_q;
    from_ram_d    = from_ram_q;
`endif

    if (busy && !ioctl_upload) begin
      state_d     = S_RELEASE;
      wait_d      = 1'b0;
      pending_d   = 1'b0;
      pause_req_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_d      = 1'b0;
          pending_d   = 1'b0;
          pause_req_d = 1'b0;
          if (ioctl_upload && !upload_prev_q) begin
            state_d     = S_PAUSE;
            pause_req_d = 1'b1;
            tmo_cnt_d   = '0;
            tmo_flag_d  = 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
            sum_d       = '0;
`endif
          end
        end

        S_PAUSE: begin
          if (ioctl_rd && !pending_q) begin
            pending_d   = 1'b1;
            pend_addr_d = ioctl_addr;
            wait_d      = 1'b1;
          end
          if (pause_ack) begin
            state_d = S_READY;
          end else if (tmo_cnt_q == TMO_END) begin
            state_d    = S_READY;
            tmo_flag_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end

        S_READY: begin
          if (req_valid) begin
            pending_d = 1'b0;
            wait_d    = 1'b1;
            if (req_ram) begin
              state_d    = S_READ;
              ram_addr_d = req_addr[AW-1:0];
              ram_rd_d   = 1'b1;
              lat_cnt_d  = '0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
              from_ram_d = 1'b1;
`endif
            end else begin
              state_d = S_DATA;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
              from_ram_d = 1'b0;
              din_d      = (req_addr == SIZE_A) ? (8'd0 - sum_q) : FILL;
`else
              din_d      = FILL;
`endif
            end
          end else begin
            wait_d = 1'b0;
          end
        end

        // lat_cnt is 0 in the ram_rd cycle, so ram_q is valid when it reaches RD_LAT.
        S_READ: begin
          if (lat_cnt_q == LAT_END) begin
            din_d   = ram_q;
            state_d = S_DATA;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          wait_d  = 1'b0;
          state_d = S_READY;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
          if (from_ram_q) begin
            sum_d = sum_q + din_q;
          end
`endif
        end

        // Forcing the edge history low lets an upload that rose here start on the next IDLE cycle.
        S_RELEASE: begin
          wait_d        = 1'b0;
          pause_req_d   = 1'b0;
          upload_prev_d = 1'b0;
          state_d       = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign pause_req  = pause_req_q;
  assign tmo_flag   = tmo_flag_q;

endmodule

// File: tb/tb_hiscore_upload.sv
// Self-checking bench for hiscore_upload: random RAM contents and reads against a byte/checksum model.
// Define HISCORE_UPLOAD_CHECKSUM_EN for both files to exercise the checksum address.
module tb_hiscore_upload;

  localparam int         AW        = 10;
  localparam int         SIZE      = 64;
  localparam int         RD_LAT    = 1;
  localparam int         PAUSE_TMO = 4095;
  localparam logic [7:0] FILL      = 8'hFF;

  logic          clk_sys;
  logic          reset_n;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;
  logic          pause_req;
  logic          pause_ack;
  logic          tmo_flag;

  int n_compared   = 0;
  int n_mismatched = 0;

  hiscore_upload #(
    .AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT), .PAUSE_TMO(PAUSE_TMO), .FILL(FILL)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
    .pause_req(pause_req), .pause_ack(pause_ack), .tmo_flag(tmo_flag)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // RAM with RD_LAT-cycle read pipeline; ram_q is garbage unless a read landed.
  logic [7:0] mem      [0:(1<<AW)-1];
  logic [7:0] lat_pipe [0:RD_LAT-1];
  always @(posedge clk_sys) begin
    lat_pipe[0] <= ram_rd ? mem[ram_addr] : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign ram_q = lat_pipe[RD_LAT-1];

  int            rd_pulses = 0;
  logic [AW-1:0] last_ram_addr = '0;
  always @(posedge clk_sys) begin
    if (ram_rd) begin
      rd_pulses     <= rd_pulses + 1;
      last_ram_addr <= ram_addr;
    end
  end

  // Model: what the HPS should see for an address, with the per-upload running byte sum.
  logic [7:0] model_sum = 8'h00;
  task automatic modelByte(input logic [24:0] addr, output logic [7:0] val);
    if (addr < 25'(SIZE)) begin
      val       = mem[addr[AW-1:0]];
      model_sum = model_sum + val;
    end
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    else if (addr == 25'(SIZE)) val = 8'h00 - model_sum;
`endif
    else val = FILL;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One HPS byte read; optionally fires an illegal second strobe while wait is high.
  task automatic applyStimulus(input logic [24:0] addr, input bit violate);
    logic [7:0] exp;
    int         pulses0;
    int         hi;
    bit         ram_path;
    modelByte(addr, exp);
    ram_path   = (addr < 25'(SIZE));
    pulses0    = rd_pulses;
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    step();
    ioctl_rd = 1'b0;
    checkOutput($sformatf("wait_rise@%0h", addr), 32'(ioctl_wait), 32'd1);
    hi = 0;
    while (ioctl_wait === 1'b1 && hi < 20) begin
      if (violate && hi == 0) begin
        ioctl_rd   = 1'b1;
        ioctl_addr = {addr[24:1], ~addr[0]};
      end
      step();
      ioctl_rd = 1'b0;
      hi++;
    end
    checkOutput($sformatf("wait_len@%0h", addr), 32'(hi), ram_path ? 32'(RD_LAT + 2) : 32'd1);
    checkOutput($sformatf("din@%0h", addr), 32'(ioctl_din), 32'(exp));
    checkOutput($sformatf("ram_rd_count@%0h", addr), 32'(rd_pulses - pulses0), ram_path ? 32'd1 : 32'd0);
    if (ram_path) checkOutput($sformatf("ram_addr@%0h", addr), 32'(last_ram_addr), 32'(addr[AW-1:0]));
  endtask

  task automatic randomReads(input int count);
    logic [24:0] a;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 25'($urandom);
        1:       a = 25'(SIZE) + 25'($urandom_range(0, 3));
        default: a = 25'($urandom_range(0, SIZE - 1));
      endcase
      applyStimulus(a, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    logic [7:0] exp;
    logic [7:0] din_keep;
    int         pulses0;
    int         n;

    reset_n      = 1'b0;
    ioctl_upload = 1'b1;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    pause_ack    = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem[5] = 8'h3C;
    mem[0] = 8'hA5;
    step();
    step();
    checkOutput("reset_din", 32'(ioctl_din), 32'd0);
    checkOutput("reset_wait", 32'(ioctl_wait), 32'd0);
    checkOutput("reset_ram_rd", 32'(ram_rd), 32'd0);
    checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("reset_pause_req", 32'(pause_req), 32'd0);
    checkOutput("reset_tmo_flag", 32'(tmo_flag), 32'd0);

    // Upload already high at reset release still counts as a rising edge.
    reset_n = 1'b1;
    step();
    model_sum = 8'h00;
    checkOutput("pause_after_reset", 32'(pause_req), 32'd1);
    step();
    step();
    checkOutput("pause_hold", 32'(pause_req), 32'd1);
    checkOutput("pause_no_wait", 32'(ioctl_wait), 32'd0);
    pause_ack = 1'b1;
    step();
    step();

    applyStimulus(25'd5, 1'b0);
    applyStimulus(25'd64, 1'b0);
    applyStimulus(25'h1000005, 1'b0);
    applyStimulus(25'(SIZE - 1), 1'b0);
    applyStimulus(25'd0, 1'b0);
    applyStimulus(25'd7, 1'b1);
    randomReads(24);

    ioctl_upload = 1'b0;
    step();
    checkOutput("release_pause_req", 32'(pause_req), 32'd0);
    pause_ack = 1'b0;
    step();
    checkOutput("idle_wait", 32'(ioctl_wait), 32'd0);

    $display("[TB] early read during pause, pause_ack held low");
    ioctl_upload = 1'b1;
    step();
    model_sum = 8'h00;
    checkOutput("tmo_pause_req", 32'(pause_req), 32'd1);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd0;
    step();
    ioctl_rd = 1'b0;
    checkOutput("early_wait", 32'(ioctl_wait), 32'd1);
    pulses0 = rd_pulses;
    repeat (3990) step();
    checkOutput("tmo_not_yet", 32'(tmo_flag), 32'd0);
    checkOutput("early_wait_held", 32'(ioctl_wait), 32'd1);
    checkOutput("early_no_ram_rd", 32'(rd_pulses - pulses0), 32'd0);
    n = 0;
    while (ioctl_wait === 1'b1 && n < 400) begin
      step();
      n++;
    end
    modelByte(25'd0, exp);
    checkOutput("early_serviced", 32'(ioctl_wait), 32'd0);
    checkOutput("tmo_flag_set", 32'(tmo_flag), 32'd1);
    checkOutput("early_din", 32'(ioctl_din), 32'(exp));
    checkOutput("early_ram_rd_count", 32'(rd_pulses - pulses0), 32'd1);
    checkOutput("early_ram_addr", 32'(last_ram_addr), 32'd0);
    din_keep = ioctl_din;

    $display("[TB] abort in the cycle after ram_rd");
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd3;
    step();
    ioctl_rd = 1'b0;
    checkOutput("abort_ram_rd", 32'(ram_rd), 32'd1);
    step();
    ioctl_upload = 1'b0;
    step();
    checkOutput("abort_wait", 32'(ioctl_wait), 32'd0);
    checkOutput("abort_pause_req", 32'(pause_req), 32'd0);
    checkOutput("abort_ram_rd_low", 32'(ram_rd), 32'd0);
    checkOutput("abort_tmo_sticky", 32'(tmo_flag), 32'd1);
    ioctl_upload = 1'b1;
    step();
    checkOutput("idle_after_release", 32'(pause_req), 32'd0);
    step();
    model_sum = 8'h00;
    checkOutput("repause", 32'(pause_req), 32'd1);
    checkOutput("repause_tmo_clear", 32'(tmo_flag), 32'd0);
    checkOutput("din_retained", 32'(ioctl_din), 32'(din_keep));

    pause_ack = 1'b1;
    step();
    step();
    for (int i = 0; i < SIZE; i++) mem[i] = 8'h01;
    for (int i = 0; i <= SIZE + 1; i++) applyStimulus(25'(i), 1'b0);
    randomReads(16);

    ioctl_upload = 1'b0;
    step();
    checkOutput("final_pause_req", 32'(pause_req), 32'd0);
    pause_ack = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hiscore_upload.md
Name: hiscore_upload

Overview:
- Serves core RAM contents to the HPS over the ioctl upload channel; the counterpart of the ioctl download path that writes ROM/NVRAM into the core.
- On upload start it halts the game CPU, then answers each HPS byte read with a RAM fetch.
- When the upload ends it releases the CPU.
- Sits in emu beside hps_io; its RAM port goes to a spare read port of the scramble_top work/hiscore RAM.

Parameters:
- AW, 10, RAM address width; window size is 2**AW bytes.
- SIZE, 64, bytes exported (1..2**AW); addresses at or above SIZE are out of range.
- RD_LAT, 1, RAM read latency in clk_sys cycles (1..3).
- PAUSE_TMO, 4095, clk_sys cycles to wait for pause_ack before proceeding anyway.
- FILL, 8'hFF, byte returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- ioctl_upload  in  1  HPS upload in progress (level)
- ioctl_rd  in  1  one-cycle byte-read strobe from HPS
- ioctl_addr  in  25  byte address, sampled when ioctl_rd=1
- ioctl_din  out  8  read data to HPS
- ioctl_wait  out  1  HPS must hold off the next ioctl_rd while high
- ram_addr  out  AW  RAM read address
- ram_rd  out  1  RAM read strobe, one cycle
- ram_q  in  8  RAM data, valid RD_LAT cycles after ram_rd
- pause_req  out  1  request CPU halt (level)
- pause_ack  in  1  CPU halted
- tmo_flag  out  1  sticky: last pause timed out

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): state IDLE; outputs ioctl_din=0, ioctl_wait=0, ram_rd=0, ram_addr=0, pause_req=0, tmo_flag=0. Any pending request and all counters are cleared.
- IDLE:
  - Rising edge of ioctl_upload (registered compare with the previous value) -> PAUSE, pause_req=1, timeout counter=0.
  - tmo_flag is cleared on entry to PAUSE.
- PAUSE:
  - pause_ack=1 -> READY.
  - Counter reaching PAUSE_TMO -> READY with tmo_flag=1.
  - ioctl_rd arriving here is latched (addr+pending) and ioctl_wait=1 is raised the next cycle. It is serviced immediately on entry to READY.
- READY: ioctl_rd (or a latched pending request):
  - In range (addr < SIZE) -> READ. ram_addr=addr[AW-1:0], ram_rd=1 for exactly one cycle, ioctl_wait=1 the cycle after ioctl_rd.
  - Out of range -> DATA directly with ioctl_din=FILL. No RAM access.
- READ: waits RD_LAT cycles after the ram_rd cycle, then captures ram_q into ioctl_din -> DATA.
- DATA: ioctl_wait=0 in this cycle -> READY. ioctl_din holds until the next capture.
- Latency: in-range ioctl_rd to ioctl_wait falling = RD_LAT+2 cycles. Out-of-range = 2 cycles.
- ioctl_rd while ioctl_wait=1 is a protocol violation; it is ignored and the in-flight request completes.
- ioctl_upload falling in any non-IDLE state:
  - Aborts any in-flight read: ram_rd=0, ioctl_wait=0, pending cleared.
  - Goes to RELEASE: pause_req=0 for one cycle, then IDLE.
  - pause_req is never held more than 1 cycle after ioctl_upload drops.
- ioctl_upload rising while in RELEASE is honoured on the following IDLE cycle.
- Address compare uses the full 25 bits; upper bits nonzero means out of range.
- ioctl_din retains its last value across uploads; it is cleared only by reset.

Optional Feature:
- Macro: HISCORE_UPLOAD_CHECKSUM_EN.
- When defined:
  - Address SIZE returns an 8-bit checksum: the two's-complement negation of the modulo-256 sum of every byte returned for addresses 0..SIZE-1 during the current upload. Bytes are accumulated in DATA; the accumulator is cleared on PAUSE entry.
  - Range becomes 0..SIZE. Address SIZE is served in 2 cycles, like the out-of-range path.
  - Addresses > SIZE return FILL.
- When not defined: address SIZE is out of range and returns FILL. No accumulator logic is present.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles with ioctl_upload=1 -> all outputs 0; after release an upload edge is still detected (IDLE→PAUSE, pause_req=1).
- Normal read: RAM[5]=8'h3C, RD_LAT=1, pause_ack after 3 cycles, then ioctl_rd addr=5 -> ram_rd one cycle with ram_addr=5; ioctl_wait high 3 cycles; ioctl_din=8'h3C when wait falls.
- Out of range: ioctl_rd addr=64 (SIZE=64, macro off) -> no ram_rd, ioctl_din=8'hFF after 2 cycles; repeat with addr=25'h1000005 -> same result.
- Early read plus timeout: pause_ack tied 0, ioctl_rd addr=0 during PAUSE -> ioctl_wait=1 held; after 4095 cycles tmo_flag=1 and the read is serviced with RAM[0].
- Abort: ioctl_upload drops in the cycle after ram_rd -> ioctl_wait=0 next cycle, pause_req low within 1 cycle, state returns to IDLE; a new upload edge re-pauses and tmo_flag is cleared.
- Checksum (macro on): RAM[0..63]=8'h01 each, read addresses 0..64 in order -> address 64 returns 8'hC0; address 65 returns 8'hFF.
